axi_aw_arbiter_router: RTL and testbench
========================================

// Module: axi_aw_arbiter_router
// PURPOSE
//  Write-address (AW) channel of the AXI bridge, generalised to NUM_M masters and NUM_S slaves plus a default slave (DS).
//  Round-robin arbitration picks one master; its AW request is decoded to one slave via the address map and forwarded.
//  Every accepted AW pushes a {master, slave} route entry into an in-order queue; the W channel steers write data by it.
//  Sits between the master AW ports and the slave AW ports inside the AXI top, next to the W and B channel blocks.
// PARAMETERS
//  NUM_M      2   number of masters (>=1)
//  NUM_S      5   number of real slaves; DS is port index NUM_S
//  ID_BITS    4   master-side AWID width
//  IDS_BITS   8   slave-side AWID width; must be >= ID_BITS+MIDX_W
//  ADDR_BITS  32  address width
//  LEN_BITS   4   AWLEN width
//  SIZE_BITS  3   AWSIZE width
//  WQ_DEPTH   4   route-queue entries (>=2, power of 2)
//  MIDX_W/SIDX_W  derived: max(1,$clog2(NUM_M)), $clog2(NUM_S+1)
// PORTS
//  clk         in   1                  clock
//  rst         in   1                  reset, asynchronous, active-high
//  AWVALID_M   in   [NUM_M]            master AW valid
//  AWID_M      in   [NUM_M][ID_BITS]   master AW id
//  AWADDR_M    in   [NUM_M][ADDR_BITS] master AW addr
//  AWLEN_M     in   [NUM_M][LEN_BITS]  burst length
//  AWSIZE_M    in   [NUM_M][SIZE_BITS] burst size
//  AWBURST_M   in   [NUM_M][2]         burst type
//  AWREADY_M   out  [NUM_M]            master AW ready
//  AWVALID_S   out  [NUM_S+1]          slave AW valid (index NUM_S = DS)
//  AWREADY_S   in   [NUM_S+1]          slave AW ready
//  AWID_S      out  [IDS_BITS]         {master index zero-ext, AWID}, shared by all slaves
//  AWADDR_S/AWLEN_S/AWSIZE_S/AWBURST_S  out  widths as master side; shared payload
//  wq_valid    out  1                  route queue non-empty
//  wq_mst      out  [MIDX_W]           head entry: master index
//  wq_slv      out  [SIDX_W]           head entry: slave index
//  wq_pop      in   1                  W channel: WLAST handshake done, pop head
// BEHAVIOUR
//  Reset: state IDLE, rr_ptr=0, queue empty; all AWVALID_S/AWREADY_M=0, payload=0, wq_valid=0.
//  Decode: first match in index order over package map (inclusive base..limit); miss -> DS (index NUM_S).
//  FSM IDLE: if any AWVALID_M and queue count<WQ_DEPTH -> pick first requester at/after rr_ptr (wrapping),
//   latch winner index and decoded target; go GRANT next cycle. Queue full -> no grant, stay IDLE.
//  FSM GRANT: payload = winner's inputs; AWVALID_S[target]=AWVALID_M[winner], others 0;
//   AWREADY_M[winner]=AWREADY_S[target], others 0. On handshake: push {winner,target}, rr_ptr=winner+1
//   (wrap at NUM_M), -> IDLE. No handshake -> hold grant indefinitely (no timeout, no re-arbitration).
//  IDLE: payload=0, all valids/readies 0. Min latency AWVALID_M -> AWVALID_S = 1 cycle; max rate 1 AW / 2 cycles.
//  Queue: FIFO, head on wq_*; push+pop same cycle keeps count; pop when empty ignored; push never overflows
//   (space reserved at grant). Count width $clog2(WQ_DEPTH)+1; pointers wrap at WQ_DEPTH.
//  Master deasserting AWVALID while granted (protocol error): valid follows input, grant held.
//  Reset asserted mid-GRANT: everything cleared immediately; in-flight AW is dropped, queue discarded.
// STRUCTURE
//  Package axi_xbar_pkg: SLV_BASE/SLV_LIMIT arrays (S1 0x0001_0000-0x0001_FFFF, S2 0x0002_0000-0x0002_FFFF,
//   S3 0x1000_0000-0x1000_03FF, S4 0x1001_0000-0x1001_03FF, S5 0x2000_0000-0x201F_FFFF), aw_state_e,
//   wq_entry_t {mst,slv}, decode function addr_to_slv().
//  Sub-module axi_route_fifo (param WIDTH, DEPTH; push/pop/full/empty/count) holds the route queue.
// TESTING
//  M0 AW addr 0x0001_0040 id 3, S0 ready -> AWVALID_S[0] 1 cycle after, AWID_S=0x03, queue head {0,0}.
//  M1 addr 0x2000_0010 id 5 -> slave 4, AWID_S=0x15, head {1,4}; addr 0x3000_0000 -> DS, head {1,5}.
//  M0,M1 request together, back-to-back x4 -> grants alternate M0,M1,M0,M1; each handshake 2 cycles apart.
//  4 AWs with no wq_pop -> 5th master stalls in IDLE, AWREADY_M=0; one wq_pop -> 5th granted next cycle.
//  S2 holds AWREADY_S=0 for 10 cycles -> grant and payload stable, other master not granted meanwhile.
//  rst pulse mid-GRANT -> outputs 0 asynchronously, wq_valid=0, rr_ptr=0 after release.

Source files
------------

// File: rtl/axi_xbar_pkg.sv
// Shared crossbar definitions: slave address map, AW arbiter states and route-queue entry.
// The route-entry field widths match the default 2-master / 5-slave-plus-DS configuration.
package axi_xbar_pkg;

    localparam int unsigned MAP_NUM  = 5;
    localparam int unsigned WQ_MST_W = 1;
    localparam int unsigned WQ_SLV_W = 3;

    localparam logic [MAP_NUM-1:0][31:0] SLV_BASE = {
        32'h2000_0000, 32'h1001_0000, 32'h1000_0000, 32'h0002_0000, 32'h0001_0000
    };
    localparam logic [MAP_NUM-1:0][31:0] SLV_LIMIT = {
        32'h201F_FFFF, 32'h1001_03FF, 32'h1000_03FF, 32'h0002_FFFF, 32'h0001_FFFF
    };

    typedef enum logic {
        AW_IDLE  = 1'b0,
        AW_GRANT = 1'b1
    } aw_state_e;

    typedef struct packed {
        logic [WQ_MST_W-1:0] mst;
        logic [WQ_SLV_W-1:0] slv;
    } wq_entry_t;

    // First matching region in index order wins; a miss selects the default slave (index num_s).
    function automatic int unsigned addr_to_slv(input logic [31:0] addr, input int unsigned num_s);
        int unsigned sel;
        logic        found;
        sel   = num_s;
        found = 1'b0;
        for (int unsigned i = 0; i < MAP_NUM; i++) begin
            if (!found && (i < num_s) && (addr >= SLV_BASE[i]) && (addr <= SLV_LIMIT[i])) begin
                sel   = i;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/axi_aw_arbiter_router_if.sv
// AW channel bundle between the master ports, the slave ports and the W-channel route queue.
interface axi_aw_arbiter_router_if #(
    parameter int unsigned NUM_M     = 2,
    parameter int unsigned NUM_S     = 5,
    parameter int unsigned ID_BITS   = 4,
    parameter int unsigned IDS_BITS  = 8,
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned LEN_BITS  = 4,
    parameter int unsigned SIZE_BITS = 3
);
    localparam int unsigned MIDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned SIDX_W = $clog2(NUM_S + 1);

    logic [NUM_M-1:0]                 awvalid_m;
    logic [NUM_M-1:0][ID_BITS-1:0]    awid_m;
    logic [NUM_M-1:0][ADDR_BITS-1:0]  awaddr_m;
    logic [NUM_M-1:0][LEN_BITS-1:0]   awlen_m;
    logic [NUM_M-1:0][SIZE_BITS-1:0]  awsize_m;
    logic [NUM_M-1:0][1:0]            awburst_m;
    logic [NUM_M-1:0]                 awready_m;

    logic [NUM_S:0]                   awvalid_s;
    logic [NUM_S:0]                   awready_s;
    logic [IDS_BITS-1:0]              awid_s;
    logic [ADDR_BITS-1:0]             awaddr_s;
    logic [LEN_BITS-1:0]              awlen_s;
    logic [SIZE_BITS-1:0]             awsize_s;
    logic [1:0]                       awburst_s;

    logic                             wq_valid;
    logic [MIDX_W-1:0]                wq_mst;
    logic [SIDX_W-1:0]                wq_slv;
    logic                             wq_pop;

    // Environment side: masters, slaves and the W channel.
    modport master (
        output awvalid_m, awid_m, awaddr_m, awlen_m, awsize_m, awburst_m, awready_s, wq_pop,
        input  awready_m, awvalid_s, awid_s, awaddr_s, awlen_s, awsize_s, awburst_s,
               wq_valid, wq_mst, wq_slv
    );

    // Arbiter/router side.
    modport slave (
        input  awvalid_m, awid_m, awaddr_m, awlen_m, awsize_m, awburst_m, awready_s, wq_pop,
        output awready_m, awvalid_s, awid_s, awaddr_s, awlen_s, awsize_s, awburst_s,
               wq_valid, wq_mst, wq_slv
    );
endinterface

// File: rtl/axi_route_fifo.sv
// In-order route queue; pushes beyond capacity and pops while empty are ignored.
module axi_route_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/axi_aw_arbiter_router.sv
// AW channel arbiter/router: round-robin master pick, address decode to a slave (or DS),
// grant held until handshake, and a {master, slave} route entry queued per accepted AW.
module axi_aw_arbiter_router
    import axi_xbar_pkg::*;
#(
    parameter int unsigned NUM_M     = 2,
    parameter int unsigned NUM_S     = 5,
    parameter int unsigned ID_BITS   = 4,
    parameter int unsigned IDS_BITS  = 8,
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned LEN_BITS  = 4,
    parameter int unsigned SIZE_BITS = 3,
    parameter int unsigned WQ_DEPTH  = 4
) (
    input logic                      clk,
    input logic                      rst,
    axi_aw_arbiter_router_if.slave   bus
);
    localparam int unsigned MIDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned SIDX_W = $clog2(NUM_S + 1);
    localparam int unsigned CNT_W  = $clog2(WQ_DEPTH) + 1;

    aw_state_e           state, state_nxt;
    logic [MIDX_W-1:0]   rr_ptr, rr_nxt;
    logic [MIDX_W-1:0]   win, win_nxt;
    logic [SIDX_W-1:0]   tgt, tgt_nxt;
    logic [MIDX_W-1:0]   pick;
    logic                push;
    logic                space;
    logic                q_full;
    logic                q_empty;
    logic [CNT_W-1:0]    q_count;
    wq_entry_t           push_entry;
    wq_entry_t           head;

    logic [NUM_S:0]          awvalid_s;
    logic [NUM_M-1:0]        awready_m;
    logic [IDS_BITS-1:0]     awid_s;
    logic [ADDR_BITS-1:0]    awaddr_s;
    logic [LEN_BITS-1:0]     awlen_s;
    logic [SIZE_BITS-1:0]    awsize_s;
    logic [1:0]              awburst_s;

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        logic found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            int unsigned idx;
            idx = (32'(rr_ptr) + i) % NUM_M;
            if (!found && bus.awvalid_m[idx]) begin
                pick  = MIDX_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign space = !q_full && (q_count < CNT_W'(WQ_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= AW_IDLE;
            rr_ptr <= '0;
            win    <= '0;
            tgt    <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            win    <= win_nxt;
            tgt    <= tgt_nxt;
        end
    end

    // Next state plus the granted pass-through of valid, ready and payload.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        win_nxt   = win;
        tgt_nxt   = tgt;
        push      = 1'b0;
        awvalid_s = '0;
        awready_m = '0;
        awid_s    = '0;
        awaddr_s  = '0;
        awlen_s   = '0;
        awsize_s  = '0;
        awburst_s = '0;
        case (state)
            AW_IDLE: begin
                if ((|bus.awvalid_m) && space) begin
                    win_nxt   = pick;
                    tgt_nxt   = SIDX_W'(addr_to_slv(32'(bus.awaddr_m[pick]), NUM_S));
                    state_nxt = AW_GRANT;
                end
            end
            AW_GRANT: begin
                awid_s         = (IDS_BITS'(win) << ID_BITS) | IDS_BITS'(bus.awid_m[win]);
                awaddr_s       = bus.awaddr_m[win];
                awlen_s        = bus.awlen_m[win];
                awsize_s       = bus.awsize_m[win];
                awburst_s      = bus.awburst_m[win];
                awvalid_s[tgt] = bus.awvalid_m[win];
                awready_m[win] = bus.awready_s[tgt];
                if (bus.awvalid_m[win] && bus.awready_s[tgt]) begin
                    push      = 1'b1;
                    rr_nxt    = (win == MIDX_W'(NUM_M - 1)) ? '0 : win + MIDX_W'(1);
                    state_nxt = AW_IDLE;
                end
            end
            default: state_nxt = AW_IDLE;
        endcase
    end

    assign push_entry.mst = WQ_MST_W'(win);
    assign push_entry.slv = WQ_SLV_W'(tgt);

    axi_route_fifo #(
        .WIDTH ($bits(wq_entry_t)),
        .DEPTH (WQ_DEPTH)
    ) u_route_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (bus.wq_pop),
        .din   (push_entry),
        .dout  (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign bus.awvalid_s = awvalid_s;
    assign bus.awready_m = awready_m;
    assign bus.awid_s    = awid_s;
    assign bus.awaddr_s  = awaddr_s;
    assign bus.awlen_s   = awlen_s;
    assign bus.awsize_s  = awsize_s;
    assign bus.awburst_s = awburst_s;
    assign bus.wq_valid  = !q_empty;
    assign bus.wq_mst    = MIDX_W'(head.mst);
    assign bus.wq_slv    = SIDX_W'(head.slv);
endmodule

// File: tb/tb_axi_aw_arbiter_router.sv
// Directed bench for the AW arbiter/router: decode, round-robin, queue back-pressure, stall and reset.
module tb_axi_aw_arbiter_router;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    axi_aw_arbiter_router_if #(
        .NUM_M(2), .NUM_S(5), .ID_BITS(4), .IDS_BITS(8),
        .ADDR_BITS(32), .LEN_BITS(4), .SIZE_BITS(3)
    ) bus ();

    axi_aw_arbiter_router #(
        .NUM_M(2), .NUM_S(5), .ID_BITS(4), .IDS_BITS(8),
        .ADDR_BITS(32), .LEN_BITS(4), .SIZE_BITS(3), .WQ_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic m, input logic [2:0] s);
        check({tag, "_valid"}, 64'(bus.wq_valid), 64'd1);
        check({tag, "_mst"},   64'(bus.wq_mst),   64'(m));
        check({tag, "_slv"},   64'(bus.wq_slv),   64'(s));
    endtask

    initial begin
        rst           = 1'b1;
        bus.awvalid_m = '0;
        bus.awid_m    = '0;
        bus.awaddr_m  = '0;
        bus.awlen_m   = '0;
        bus.awsize_m  = '0;
        bus.awburst_m = '0;
        bus.awready_s = 6'b111111;
        bus.wq_pop    = 1'b0;
        tick();
        tick();
        check("rst_awvalid_s", 64'(bus.awvalid_s), 64'd0);
        check("rst_awready_m", 64'(bus.awready_m), 64'd0);
        check("rst_awaddr_s",  64'(bus.awaddr_s),  64'd0);
        check("rst_wq_valid",  64'(bus.wq_valid),  64'd0);
        rst = 1'b0;

        // M0 to S1 region (port 0)
        bus.awaddr_m[0] = 32'h0001_0040;
        bus.awid_m[0]   = 4'd3;
        bus.awvalid_m   = 2'b01;
        check("idle_no_valid", 64'(bus.awvalid_s), 64'd0);
        tick();
        check("m0_awvalid_s", 64'(bus.awvalid_s), 64'h01);
        check("m0_awid_s",    64'(bus.awid_s),    64'h03);
        check("m0_awaddr_s",  64'(bus.awaddr_s),  64'h0001_0040);
        check("m0_awready_m", 64'(bus.awready_m), 64'h1);
        tick();
        bus.awvalid_m = 2'b00;
        check("m0_post_valid", 64'(bus.awvalid_s), 64'd0);
        check_head("m0_head", 1'b0, 3'd0);
        bus.wq_pop = 1'b1;
        tick();
        bus.wq_pop = 1'b0;
        check("pop_empty", 64'(bus.wq_valid), 64'd0);

        // M1 to S5 region (port 4), then a miss to DS
        bus.awaddr_m[1] = 32'h2000_0010;
        bus.awid_m[1]   = 4'd5;
        bus.awvalid_m   = 2'b10;
        tick();
        check("m1_awvalid_s", 64'(bus.awvalid_s), 64'h10);
        check("m1_awid_s",    64'(bus.awid_s),    64'h15);
        check("m1_awready_m", 64'(bus.awready_m), 64'h2);
        tick();
        check_head("m1_head", 1'b1, 3'd4);
        bus.awaddr_m[1] = 32'h3000_0000;
        bus.wq_pop      = 1'b1;
        tick();
        bus.wq_pop = 1'b0;
        check("ds_awvalid_s", 64'(bus.awvalid_s), 64'h20);
        check("ds_awid_s",    64'(bus.awid_s),    64'h15);
        check("ds_q_empty",   64'(bus.wq_valid),  64'd0);
        tick();
        bus.awvalid_m = 2'b00;
        check_head("ds_head", 1'b1, 3'd5);
        bus.wq_pop = 1'b1;
        tick();
        bus.wq_pop = 1'b0;

        // Both masters back-to-back: grants alternate, queue fills to 4
        bus.awaddr_m[0] = 32'h0002_0000;
        bus.awid_m[0]   = 4'd1;
        bus.awaddr_m[1] = 32'h1000_0000;
        bus.awid_m[1]   = 4'd2;
        bus.awvalid_m   = 2'b11;
        for (int g = 0; g < 4; g++) begin
            tick();
            check($sformatf("rr_ready_%0d", g), 64'(bus.awready_m), (g % 2 == 1) ? 64'h2 : 64'h1);
            check($sformatf("rr_valid_%0d", g), 64'(bus.awvalid_s), (g % 2 == 1) ? 64'h04 : 64'h02);
            tick();
        end
        tick();
        check("full_ready_a", 64'(bus.awready_m), 64'd0);
        check("full_valid_a", 64'(bus.awvalid_s), 64'd0);
        tick();
        check("full_valid_b", 64'(bus.awvalid_s), 64'd0);
        check_head("full_head", 1'b0, 3'd1);
        bus.wq_pop = 1'b1;
        tick();
        bus.wq_pop = 1'b0;
        check("pop_cycle_valid", 64'(bus.awvalid_s), 64'd0);
        tick();
        check("fifth_ready", 64'(bus.awready_m), 64'h1);
        check("fifth_valid", 64'(bus.awvalid_s), 64'h02);
        tick();
        bus.awvalid_m = 2'b00;
        check_head("q0", 1'b1, 3'd2);
        bus.wq_pop = 1'b1;
        tick();
        check_head("q1", 1'b0, 3'd1);
        tick();
        check_head("q2", 1'b1, 3'd2);
        tick();
        check_head("q3", 1'b0, 3'd1);
        tick();
        check("q_drained", 64'(bus.wq_valid), 64'd0);
        tick();
        bus.wq_pop = 1'b0;
        check("pop_while_empty", 64'(bus.wq_valid), 64'd0);

        // S2 stalls for 10 cycles; grant and payload hold, M1 waits
        bus.awready_s    = 6'b111101;
        bus.awaddr_m[0]  = 32'h0002_0100;
        bus.awid_m[0]    = 4'd7;
        bus.awlen_m[0]   = 4'd3;
        bus.awsize_m[0]  = 3'd2;
        bus.awburst_m[0] = 2'd1;
        bus.awvalid_m    = 2'b01;
        tick();
        bus.awaddr_m[1] = 32'h0001_0000;
        bus.awid_m[1]   = 4'd4;
        bus.awvalid_m   = 2'b11;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("stall_valid_%0d", c), 64'(bus.awvalid_s), 64'h02);
            check($sformatf("stall_ready_%0d", c), 64'(bus.awready_m), 64'd0);
            check($sformatf("stall_addr_%0d", c),  64'(bus.awaddr_s),  64'h0002_0100);
            check($sformatf("stall_id_%0d", c),    64'(bus.awid_s),    64'h07);
            check($sformatf("stall_len_%0d", c),   64'(bus.awlen_s),   64'h3);
            tick();
        end
        check("stall_burst", 64'(bus.awburst_s), 64'h1);
        bus.awready_s = 6'b111111;
        #1;
        check("stall_release", 64'(bus.awready_m), 64'h1);
        tick();
        bus.awvalid_m = 2'b10;
        check_head("stall_head", 1'b0, 3'd1);
        tick();
        check("after_ready", 64'(bus.awready_m), 64'h2);
        check("after_valid", 64'(bus.awvalid_s), 64'h01);
        check("after_id",    64'(bus.awid_s),    64'h14);
        tick();
        bus.awvalid_m = 2'b00;

        // Reset during a held grant
        bus.awaddr_m[0] = 32'h1001_0000;
        bus.awid_m[0]   = 4'd9;
        bus.awvalid_m   = 2'b01;
        tick();
        check("pre_rst_valid", 64'(bus.awvalid_s), 64'h08);
        tick();
        bus.awready_s = 6'b110111;
        tick();
        check("held_valid", 64'(bus.awvalid_s), 64'h08);
        check("held_ready", 64'(bus.awready_m), 64'd0);
        bus.awaddr_m[1] = 32'h0001_0000;
        bus.awvalid_m   = 2'b11;
        rst = 1'b1;
        #1;
        check("async_valid",    64'(bus.awvalid_s), 64'd0);
        check("async_ready",    64'(bus.awready_m), 64'd0);
        check("async_addr",     64'(bus.awaddr_s),  64'd0);
        check("async_id",       64'(bus.awid_s),    64'd0);
        check("async_wq_valid", 64'(bus.wq_valid),  64'd0);
        tick();
        check("in_rst_valid", 64'(bus.awvalid_s), 64'd0);
        rst           = 1'b0;
        bus.awready_s = 6'b111111;
        tick();
        check("post_rst_rr", 64'(bus.awready_m), 64'h1);
        tick();
        bus.awvalid_m = 2'b00;
        check_head("post_rst_head", 1'b0, 3'd3);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
